sme_job_sched: RTL and testbench
================================

Name: sme_job_sched

Overview:
Two-requester job scheduler in front of the string-match engine (one string up to 32 chars, one pattern up to 8 chars, answers valid/match/index). Each requester submits a job as a byte stream: an optional string segment, then a pattern segment. The scheduler round-robins between requesters and buffers the whole job locally. It replays the job to the engine as one contiguous isstring/ispattern burst, then returns a tagged result. The string buffer persists, so pattern-only jobs reuse the last loaded string.

Parameters:
STR_MAX, 32, maximum string length in bytes
PAT_MAX, 8, maximum pattern length in bytes
TIMEOUT, 64, WAIT-state cycles allowed for eng_valid before an error response

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester byte valid
req_ready  out  2  per-requester byte accept; only the granted bit can be 1
req_data  in  16  requester n byte on [8n+7:8n]
req_kind  in  2  per requester: 0 = string byte, 1 = pattern byte
req_last  in  2  per requester: marks the final byte of the job
eng_chardata  out  8  byte to engine
eng_isstring  out  1  string byte strobe
eng_ispattern  out  1  pattern byte strobe
eng_valid  in  1  engine result strobe
eng_match  in  1  engine match flag
eng_index  in  5  engine match index
rsp_valid  out  1  result valid, held until rsp_ready
rsp_ready  in  1  result consumer accept
rsp_id  out  1  requester that owns the result
rsp_match  out  1  match flag
rsp_index  out  5  match index; 0 when there is no match or an error
rsp_error  out  1  job rejected or timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. All outputs go to 0. str_loaded, str_len, pat_len, rr_ptr and the timeout counter clear. Buffer contents need no reset.
- States:
  - IDLE: stay if req_valid==0.
  - ARB: grant one requester, then LOAD.
  - LOAD: accept bytes into the buffers.
  - CHECK: 1 cycle; decide between SEND and RESP (error).
  - SEND_STR
  - SEND_PAT
  - WAIT
  - RESP
- Arbitration: if both requesters are valid, grant !rr_ptr. rr_ptr updates to the granted id when the grant is made. If only one is valid, grant it. The grant is held until RESP completes.
- LOAD:
  - req_ready[g]=1; one byte is accepted per cycle when req_valid[g] is high. Bubbles are allowed.
  - String bytes go to str_buf[str_len++]. The first string byte of a job clears str_len to 0 before the write.
  - Pattern bytes go to pat_buf[pat_len++]; pat_len clears at ARB.
  - The accepted byte with req_last moves the FSM to CHECK.
- Error conditions, latched during LOAD and evaluated in CHECK. Bytes are still consumed until last; the job is never sent to the engine; the response is rsp_error=1, rsp_match=0.
  - String length > STR_MAX, or pattern length > PAT_MAX; excess bytes are not written.
  - Pattern length == 0.
  - A string byte arriving after a pattern byte.
  - A pattern-only job while str_loaded==0.
  - Any job whose string segment errored clears str_loaded.
- SEND_STR: entered only when the job carried string bytes.
  - eng_isstring=1 and eng_chardata=str_buf[i] for exactly str_len consecutive cycles.
  - Sets str_loaded at the end.
- SEND_PAT:
  - Follows SEND_STR with no gap, or follows CHECK directly for a pattern-only job.
  - eng_ispattern=1 for pat_len consecutive cycles.
- Strobes: eng_isstring and eng_ispattern are never high together, and both are registered outputs.
- WAIT:
  - Both strobes are low and eng_chardata=0.
  - On eng_valid: latch eng_match and eng_index (index forced to 0 if match==0), go to RESP.
  - After TIMEOUT cycles without eng_valid: rsp_error=1, go to RESP.
  - eng_valid outside WAIT is ignored.
- RESP:
  - rsp_valid=1 with stable id/match/index/error until rsp_ready is sampled high.
  - Then go to ARB if any req_valid is high, else IDLE.
  - rsp_valid drops the next cycle.
- Latency, when eng_valid arrives 1 cycle into WAIT: rsp_valid rises str_len + pat_len + 3 cycles after the last byte is accepted.
- Simultaneous events: rsp_ready together with a new req_valid leads to ARB in the following cycle. No byte is accepted in RESP.

Decomposition:
- Shared package sme_pkg:
  - state enum SCHED_IDLE..SCHED_RESP
  - CHAR_SPACE=8'h20, CHAR_DOT=8'h2E, CHAR_CARET=8'h5E, CHAR_DOLLAR=8'h24
  - STR_MAX and PAT_MAX defaults
- One natural sub-module: sme_rr_arb2, a 2-way round-robin grant with a pointer register.
- The buffers and FSM stay in the top.

Test Plan:
1. Requester 0 sends string "ABCD" then pattern "BC" (last on 'C') -> engine sees isstring for 4 cycles ('A','B','C','D'), then ispattern for 2 cycles ('B','C') with no gap. Model returns match=1, index=1 -> rsp_valid, rsp_id=0, rsp_match=1, rsp_index=1, rsp_error=0.
2. After test 1, requester 1 sends pattern-only "D" -> no isstring cycles, ispattern for 1 cycle. Model returns match=1, index=3 -> rsp_id=1, rsp_index=3.
3. Both requesters valid together from IDLE with rr_ptr=0 -> requester 1 granted first (req_ready=2'b10). Requester 0 is served after rsp_ready.
4. Pattern-only job right after reset -> no engine strobes at all; rsp_error=1, rsp_match=0, rsp_index=0.
5. 9-byte pattern -> all 9 bytes accepted, no engine strobes, rsp_error=1. A 33-byte string behaves the same way.
6. Engine never returns valid -> after 64 WAIT cycles rsp_error=1. Holding rsp_ready=0 for 5 cycles keeps rsp_valid and all rsp fields stable. Asserting reset mid-SEND_STR drops the strobes to 0 immediately and busy goes to 0.

Source files
------------

// File: rtl/sme_pkg.sv
// sme_pkg: shared state encoding, character constants and size defaults for the string-match job scheduler
package sme_pkg;
    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_ARB,
        SCHED_LOAD,
        SCHED_CHECK,
        SCHED_SEND_STR,
        SCHED_SEND_PAT,
        SCHED_WAIT,
        SCHED_RESP
    } sched_state_t;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam logic [7:0] CHAR_DOT    = 8'h2E;
    localparam logic [7:0] CHAR_CARET  = 8'h5E;
    localparam logic [7:0] CHAR_DOLLAR = 8'h24;
    localparam int SME_STR_MAX = 32;
    localparam int SME_PAT_MAX = 8;
endpackage

// File: rtl/sme_rr_arb2.sv
// sme_rr_arb2: 2-way round-robin grant (gnt = granted id) with pointer updated on take
module sme_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);
    logic ptr;
    assign gnt = &req ? !ptr : req[1];
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr <= 1'b0;
        else if (take) ptr <= gnt;
endmodule

// File: rtl/sme_job_sched.sv
// sme_job_sched: two-requester job buffer/scheduler replaying string+pattern bursts to the match engine and returning tagged results
module sme_job_sched
    import sme_pkg::*;
#(
    parameter int STR_MAX = SME_STR_MAX,
    parameter int PAT_MAX = SME_PAT_MAX,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_kind,
    input  logic [1:0]  req_last,
    output logic [7:0]  eng_chardata,
    output logic        eng_isstring,
    output logic        eng_ispattern,
    input  logic        eng_valid,
    input  logic        eng_match,
    input  logic [4:0]  eng_index,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic        rsp_match,
    output logic [4:0]  rsp_index,
    output logic        rsp_error,
    output logic        busy
);
    localparam int SA = $clog2(STR_MAX);
    localparam int SL = $clog2(STR_MAX + 1);
    localparam int PA = $clog2(PAT_MAX);
    localparam int PL = $clog2(PAT_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    sched_state_t state;
    logic [7:0] str_buf [STR_MAX];
    logic [7:0] pat_buf [PAT_MAX];
    logic [SL-1:0] str_len, sidx, cnt;
    logic [PL-1:0] pat_len;
    logic [TW-1:0] tmo;
    logic g, gnt, str_loaded, seen_str, seen_pat, str_err, pat_err;
    logic acc, kind, last, s_wr, p_wr;
    logic [7:0] d;
    sme_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .take  (state == SCHED_ARB && |req_valid),
        .gnt   (gnt)
    );
    assign req_ready = state == SCHED_LOAD ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign busy = state != SCHED_IDLE;
    assign acc  = state == SCHED_LOAD && req_valid[g];
    assign d    = g ? req_data[15:8] : req_data[7:0];
    assign kind = req_kind[g];
    assign last = req_last[g];
    assign sidx = seen_str ? str_len : '0;
    // string bytes after a pattern byte or past capacity are consumed but dropped
    assign s_wr = acc && !kind && !seen_pat && sidx < SL'(STR_MAX);
    assign p_wr = acc && kind && pat_len < PL'(PAT_MAX);
    always_ff @(posedge clk) begin
        if (s_wr) str_buf[sidx[SA-1:0]] <= d;
        if (p_wr) pat_buf[pat_len[PA-1:0]] <= d;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SCHED_IDLE;
            g <= 1'b0;
            str_loaded <= 1'b0;
            str_len <= '0;
            pat_len <= '0;
            cnt <= '0;
            tmo <= '0;
            seen_str <= 1'b0;
            seen_pat <= 1'b0;
            str_err <= 1'b0;
            pat_err <= 1'b0;
            eng_chardata <= '0;
            eng_isstring <= 1'b0;
            eng_ispattern <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id <= 1'b0;
            rsp_match <= 1'b0;
            rsp_index <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                SCHED_IDLE: if (|req_valid) state <= SCHED_ARB;
                SCHED_ARB: begin
                    if (|req_valid) begin
                        g <= gnt;
                        pat_len <= '0;
                        seen_str <= 1'b0;
                        seen_pat <= 1'b0;
                        str_err <= 1'b0;
                        pat_err <= 1'b0;
                        state <= SCHED_LOAD;
                    end else state <= SCHED_IDLE;
                end
                SCHED_LOAD: begin
                    if (acc) begin
                        if (kind) begin
                            seen_pat <= 1'b1;
                            if (p_wr) pat_len <= pat_len + PL'(1);
                            else pat_err <= 1'b1;
                        end else begin
                            seen_str <= 1'b1;
                            if (s_wr) str_len <= sidx + SL'(1);
                            else str_err <= 1'b1;
                        end
                        if (last) state <= SCHED_CHECK;
                    end
                end
                SCHED_CHECK: begin
                    if (str_err || pat_err || pat_len == '0 || (!seen_str && !str_loaded)) begin
                        if (str_err) str_loaded <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id <= g;
                        rsp_match <= 1'b0;
                        rsp_index <= '0;
                        rsp_error <= 1'b1;
                        state <= SCHED_RESP;
                    end else if (seen_str) begin
                        eng_isstring <= 1'b1;
                        eng_chardata <= str_buf[0];
                        cnt <= SL'(1);
                        state <= SCHED_SEND_STR;
                    end else begin
                        eng_ispattern <= 1'b1;
                        eng_chardata <= pat_buf[0];
                        cnt <= SL'(1);
                        state <= SCHED_SEND_PAT;
                    end
                end
                SCHED_SEND_STR: begin
                    // hand over to the pattern in the same edge so the burst has no gap
                    if (cnt == str_len) begin
                        eng_isstring <= 1'b0;
                        eng_ispattern <= 1'b1;
                        eng_chardata <= pat_buf[0];
                        cnt <= SL'(1);
                        str_loaded <= 1'b1;
                        state <= SCHED_SEND_PAT;
                    end else begin
                        eng_chardata <= str_buf[cnt[SA-1:0]];
                        cnt <= cnt + SL'(1);
                    end
                end
                SCHED_SEND_PAT: begin
                    if (cnt == SL'(pat_len)) begin
                        eng_ispattern <= 1'b0;
                        eng_chardata <= '0;
                        tmo <= '0;
                        state <= SCHED_WAIT;
                    end else begin
                        eng_chardata <= pat_buf[cnt[PA-1:0]];
                        cnt <= cnt + SL'(1);
                    end
                end
                SCHED_WAIT: begin
                    if (eng_valid || tmo == TW'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_id <= g;
                        rsp_match <= eng_valid && eng_match;
                        rsp_index <= eng_valid && eng_match ? eng_index : '0;
                        rsp_error <= !eng_valid;
                        state <= SCHED_RESP;
                    end else tmo <= tmo + TW'(1);
                end
                SCHED_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state <= |req_valid ? SCHED_ARB : SCHED_IDLE;
                    end
                end
                default: state <= SCHED_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sme_job_sched.sv
// tb_sme_job_sched: scoreboard bench with directed jobs, an engine model and decoupled response/engine monitors
module tb_sme_job_sched;
    import sme_pkg::*;
    typedef struct packed {logic id; logic m; logic [4:0] idx; logic err;} rsp_t;
    typedef struct packed {logic v; logic m; logic [4:0] idx;} rep_t;
    logic clk = 1'b0, reset = 1'b1;
    logic rv0 = 0, rv1 = 0, k0 = 0, k1 = 0, l0 = 0, l1 = 0;
    logic [7:0] d0 = 0, d1 = 0;
    logic [1:0] req_valid, req_ready, req_kind, req_last;
    logic [15:0] req_data;
    logic [7:0] eng_chardata;
    logic eng_isstring, eng_ispattern, eng_valid = 0, eng_match = 0;
    logic [4:0] eng_index = 0;
    logic rsp_valid, rsp_ready = 1, rsp_id, rsp_match, rsp_error, busy;
    logic [4:0] rsp_index;
    int checks = 0, errors = 0;
    bit ignore_eng = 0, just_popped = 0;
    rsp_t exp_rsp[$];
    logic [8:0] exp_eng[$];
    rep_t replies[$];
    assign req_valid = {rv1, rv0};
    assign req_data = {d1, d0};
    assign req_kind = {k1, k0};
    assign req_last = {l1, l0};
    always #5 clk = ~clk;
    sme_job_sched dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_kind(req_kind), .req_last(req_last),
        .eng_chardata(eng_chardata), .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern),
        .eng_valid(eng_valid), .eng_match(eng_match), .eng_index(eng_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_match(rsp_match),
        .rsp_index(rsp_index), .rsp_error(rsp_error), .busy(busy)
    );
    task automatic set_req(input int r, input logic v, input logic [7:0] c, input logic k, input logic l);
        if (r == 0) begin rv0 = v; d0 = c; k0 = k; l0 = l; end
        else begin rv1 = v; d1 = c; k1 = k; l1 = l; end
    endtask
    task automatic drive(input int r, input string s, input string p, input string t);
        int n;
        logic [7:0] c;
        logic k;
        bit ok;
        n = s.len() + p.len() + t.len();
        for (int i = 0; i < n; i++) begin
            if (i < s.len()) begin c = s[i]; k = 0; end
            else if (i < s.len() + p.len()) begin c = p[i - s.len()]; k = 1; end
            else begin c = t[i - s.len() - p.len()]; k = 0; end
            set_req(r, 1, c, k, i == n - 1);
            ok = 0;
            for (int w = 0; w < 400 && !ok; w++) begin
                @(negedge clk);
                if (req_ready[r]) ok = 1;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL accept_timeout req%0d byte %0d: ready=%b required=1", r, i, req_ready[r]);
            end
            @(posedge clk); #1;
        end
        set_req(r, 0, 8'h00, 0, 0);
    endtask
    task automatic expect_job(input int r, input string s, input string p, input bit err,
                              input bit rv, input bit m, input logic [4:0] idx);
        rsp_t e;
        if (!err) begin
            for (int i = 0; i < s.len(); i++) exp_eng.push_back({1'b0, 8'(s[i])});
            for (int i = 0; i < p.len(); i++) exp_eng.push_back({1'b1, 8'(p[i])});
            replies.push_back({rv, m, idx});
        end
        e.id = r[0];
        e.err = err || !rv;
        e.m = !e.err && m;
        e.idx = e.m ? idx : 5'd0;
        exp_rsp.push_back(e);
    endtask
    task automatic job(input int r, input string s, input string p, input bit err,
                       input bit rv, input bit m, input logic [4:0] idx);
        expect_job(r, s, p, err, rv, m, idx);
        drive(r, s, p, "");
    endtask
    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int w = 0; w < 2000 && !ok; w++) begin
            @(negedge clk);
            if (!busy && exp_rsp.size() == 0) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_idle: busy=%b pending=%0d required busy=0 pending=0", name, busy, exp_rsp.size());
        end
    endtask
    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset) just_popped = 0;
            else if (just_popped) begin
                checks++;
                if (rsp_valid) begin
                    errors++;
                    $display("FAIL rsp_drop: rsp_valid=%b required=0", rsp_valid);
                end
                just_popped = 0;
            end else if (rsp_valid) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: id=%b match=%b index=%0d error=%b required none",
                             rsp_id, rsp_match, rsp_index, rsp_error);
                end else begin
                    e = exp_rsp[0];
                    if ({rsp_id, rsp_match, rsp_index, rsp_error} !== e) begin
                        errors++;
                        $display("FAIL rsp: id=%b match=%b index=%0d error=%b required id=%b match=%b index=%0d error=%b",
                                 rsp_id, rsp_match, rsp_index, rsp_error, e.id, e.m, e.idx, e.err);
                    end
                    if (rsp_ready) begin
                        void'(exp_rsp.pop_front());
                        just_popped = 1;
                    end
                end
            end
        end
    end
    initial begin : eng_model
        logic prev;
        logic [8:0] x;
        rep_t rp;
        prev = 0;
        forever begin
            @(negedge clk);
            if (reset || ignore_eng) prev = 0;
            else begin
                if (eng_isstring || eng_ispattern) begin
                    checks++;
                    if (eng_isstring && eng_ispattern) begin
                        errors++;
                        $display("FAIL strobe_overlap: isstring=1 ispattern=1 required one");
                    end else if (exp_eng.size() == 0) begin
                        errors++;
                        $display("FAIL eng_unexpected: pat=%b char=%h required no strobe", eng_ispattern, eng_chardata);
                    end else begin
                        x = exp_eng.pop_front();
                        if ({eng_ispattern, eng_chardata} !== x) begin
                            errors++;
                            $display("FAIL eng_byte: pat=%b char=%h required pat=%b char=%h",
                                     eng_ispattern, eng_chardata, x[8], x[7:0]);
                        end
                    end
                end
                if (prev && !eng_ispattern) begin
                    checks++;
                    if ({eng_isstring, eng_chardata} !== 9'd0) begin
                        errors++;
                        $display("FAIL wait_idle_bus: isstring=%b char=%h required 0", eng_isstring, eng_chardata);
                    end
                    if (replies.size() != 0) begin
                        rp = replies.pop_front();
                        if (rp.v) begin
                            @(posedge clk); #1;
                            eng_valid = 1; eng_match = rp.m; eng_index = rp.idx;
                            @(posedge clk); #1;
                            eng_valid = 0; eng_match = 1; eng_index = 5'd31;
                        end
                    end
                end
                prev = eng_ispattern;
            end
        end
    end
    initial begin
        bit ok;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, eng_chardata, eng_isstring, eng_ispattern, rsp_valid, rsp_id, rsp_match, rsp_index, rsp_error, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b char=%h s=%b p=%b rv=%b busy=%b required all 0",
                     req_ready, eng_chardata, eng_isstring, eng_ispattern, rsp_valid, busy);
        end
        reset = 0;
        @(posedge clk); #1;
        job(0, "", "A", 1, 0, 0, 0);
        wait_idle("pat_only_unloaded");
        job(0, "ABCD", "BC", 0, 1, 1, 5'd1);
        wait_idle("str_pat");
        expect_job(1, "", "D", 0, 1, 1, 5'd3);
        expect_job(0, "", "AB", 0, 1, 0, 5'd7);
        fork
            drive(1, "", "D", "");
            drive(0, "", "AB", "");
            begin
                ok = 0;
                for (int w = 0; w < 50 && !ok; w++) begin
                    @(negedge clk);
                    if (req_ready != 2'b00) ok = 1;
                end
                checks++;
                if (req_ready !== 2'b10) begin
                    errors++;
                    $display("FAIL rr_grant: req_ready=%b required=10", req_ready);
                end
            end
        join
        wait_idle("rr");
        job(0, "", "ABCDEFGHI", 1, 0, 0, 0);
        wait_idle("pat_over");
        job(1, "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456", "A", 1, 0, 0, 0);
        wait_idle("str_over");
        job(0, "", "A", 1, 0, 0, 0);
        wait_idle("str_cleared");
        job(1, {"HELLO", string'(CHAR_SPACE), "WORLD"}, "WORLD", 0, 1, 1, 5'd6);
        wait_idle("reload");
        expect_job(0, "AB", "C", 1, 0, 0, 0);
        drive(0, "AB", "C", "D");
        wait_idle("order");
        job(1, "", "W", 1, 0, 0, 0);
        wait_idle("order_cleared");
        rsp_ready = 0;
        job(0, "XY", "Y", 0, 0, 0, 0);
        ok = 0;
        for (int w = 0; w < 300 && !ok; w++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_rsp: rsp_valid=0 required=1");
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1;
        wait_idle("timeout");
        ignore_eng = 1;
        drive(0, "ABCDEFGH", "A", "");
        ok = 0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (eng_isstring) ok = 1;
        end
        reset = 1;
        #1;
        checks++;
        if (!ok || {eng_isstring, eng_ispattern, eng_chardata, busy, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: seen=%b s=%b p=%b char=%h busy=%b required seen=1 rest 0",
                     ok, eng_isstring, eng_ispattern, eng_chardata, busy);
        end
        exp_eng.delete(); replies.delete(); exp_rsp.delete();
        @(negedge clk);
        reset = 0;
        ignore_eng = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_eng.size() != 0 || replies.size() != 0) begin
            errors++;
            $display("FAIL post_reset: busy=%b eng_pending=%0d required busy=0 pending=0", busy, exp_eng.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
